// File: rtl/lr_sc_unit_pkg.sv
// Shared types and constants for the LR/SC reservation unit.
package lr_sc_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LR_RD = 2'd1,
        SC_WR = 2'd2,
        DONE  = 2'd3
    } lr_sc_state_t;

    localparam logic SC_SUCCESS = 1'b0;
    localparam logic SC_FAIL    = 1'b1;

    // RV-A (AMO) major opcode
    localparam logic [6:0] OPCODE_AMO = 7'b0101111;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/lr_sc_unit_if.sv
// Memory-side bus of the LR/SC unit.
// A request (mem_rd or mem_wr) holds mem_addr/mem_wdata stable and completes in the cycle mem_ready=1.
interface lr_sc_unit_if #(parameter int XLEN = 32);
    logic            mem_rd;
    logic            mem_wr;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ready;
    logic [XLEN-1:0] mem_rdata;

    modport master (output mem_rd, mem_wr, mem_addr, mem_wdata,
                    input  mem_ready, mem_rdata);
    modport slave  (input  mem_rd, mem_wr, mem_addr, mem_wdata,
                    output mem_ready, mem_rdata);
endinterface

// File: rtl/lr_sc_unit_reservation.sv
// Single-entry load reservation: valid bit, reserved word address, hit and snoop compare.
module lr_reservation
    import lr_sc_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set,
    input  logic            clear,
    input  logic [XLEN-1:0] set_addr,
    input  logic [XLEN-1:0] lookup_addr,
    input  logic            snoop_wr,
    input  logic [XLEN-1:0] snoop_addr,
    output logic            hit
);

    logic            valid;
    logic [XLEN-1:0] word;
    logic            snoop_res;
    logic            snoop_set;

    assign snoop_res = snoop_wr && ((snoop_addr >> 2) == word);
    assign snoop_set = snoop_wr && ((snoop_addr >> 2) == (set_addr >> 2));
    assign hit       = valid && ((lookup_addr >> 2) == word) && !snoop_res;

    // Clearing wins over setting; a store racing the LR completion kills the new reservation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            word  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (set) begin
            valid <= !snoop_set;
            word  <= set_addr >> 2;
        end else if (snoop_res) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/lr_sc_unit.sv
// LR/SC execution unit: issues the bus access, tracks the reservation, reports SC status.
module lr_sc_unit
    import lr_sc_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_atomic,
    input  logic            i_sc,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic            i_snoop_wr,
    input  logic [XLEN-1:0] i_snoop_addr,
    input  logic            i_flush,
    output logic            o_mem_rd,
    output logic            o_mem_wr,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_wdata,
    input  logic            i_mem_ready,
    input  logic [XLEN-1:0] i_mem_rdata,
    output logic            o_stall,
    output logic            o_done,
    output logic [XLEN-1:0] o_rdata,
    output logic            o_ex_misaligned
);

    lr_sc_state_t    state;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rdata_q;
    logic            misal_q;
    logic            kill_q;

    logic accept;
    logic misal;
    logic res_hit;
    logic res_set;
    logic res_clear;

    assign accept    = (state == IDLE) && i_atomic && !i_flush;
    assign misal     = is_misaligned(i_addr[1:0]);
    assign res_set   = (state == LR_RD) && i_mem_ready && !kill_q && !i_flush;
    assign res_clear = i_flush || (accept && i_sc && !misal);

    lr_reservation #(.XLEN(XLEN)) u_reservation (
        .clk         (i_clk),
        .rst         (i_rst),
        .set         (res_set),
        .clear       (res_clear),
        .set_addr    (addr_q),
        .lookup_addr (i_addr),
        .snoop_wr    (i_snoop_wr),
        .snoop_addr  (i_snoop_addr),
        .hit         (res_hit)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            misal_q <= 1'b0;
            kill_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= i_addr;
                        wdata_q <= i_wdata;
                        misal_q <= misal;
                        kill_q  <= 1'b0;
                        if (misal) begin
                            state   <= DONE;
                            rdata_q <= '0;
                        end else if (!i_sc) begin
                            state <= LR_RD;
                        end else if (res_hit) begin
                            state <= SC_WR;
                        end else begin
                            state   <= DONE;
                            rdata_q <= XLEN'(SC_FAIL);
                        end
                    end
                end
                LR_RD, SC_WR: begin
                    // A flushed access still completes on the bus but never reports.
                    if (i_mem_ready) begin
                        state   <= (kill_q || i_flush) ? IDLE : DONE;
                        rdata_q <= (state == LR_RD) ? i_mem_rdata : XLEN'(SC_SUCCESS);
                    end else if (i_flush) begin
                        kill_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_mem_rd        = (state == LR_RD);
    assign o_mem_wr        = (state == SC_WR);
    assign o_mem_addr      = addr_q;
    assign o_mem_wdata     = wdata_q;
    assign o_stall         = accept || o_mem_rd || o_mem_wr;
    assign o_done          = (state == DONE) && !i_flush;
    assign o_ex_misaligned = o_done && misal_q;
    assign o_rdata         = rdata_q;

endmodule

// File: tb/tb_lr_sc_unit.sv
// Directed bench for lr_sc_unit with a transaction-level reservation/memory model.
module tb_lr_sc_unit;
  import lr_sc_unit_pkg::*;

  localparam int XLEN = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            atomic = 1'b0, sc = 1'b0, flush = 1'b0, snoop_wr = 1'b0;
  logic [XLEN-1:0] addr = '0, wdata = '0, snoop_addr = '0;
  logic            stall, done, misal;
  logic [XLEN-1:0] rdata;

  lr_sc_unit_if #(.XLEN(XLEN)) bus ();

  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
  end

  lr_sc_unit #(.XLEN(XLEN)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_atomic        (atomic),
    .i_sc            (sc),
    .i_addr          (addr),
    .i_wdata         (wdata),
    .i_snoop_wr      (snoop_wr),
    .i_snoop_addr    (snoop_addr),
    .i_flush         (flush),
    .o_mem_rd        (bus.mem_rd),
    .o_mem_wr        (bus.mem_wr),
    .o_mem_addr      (bus.mem_addr),
    .o_mem_wdata     (bus.mem_wdata),
    .i_mem_ready     (bus.mem_ready),
    .i_mem_rdata     (bus.mem_rdata),
    .o_stall         (stall),
    .o_done          (done),
    .o_rdata         (rdata),
    .o_ex_misaligned (misal)
  );

  // ---------------- model state ----------------
  logic            m_valid = 1'b0;
  logic [XLEN-1:0] m_word  = '0;
  logic [XLEN-1:0] mem [logic [XLEN-1:0]];

  logic            exp_stall = 0, exp_rd = 0, exp_wr = 0, exp_done = 0, exp_misal = 0;
  logic [XLEN-1:0] exp_addr = '0, exp_wdata = '0;
  logic [XLEN-1:0] exp_q [$];

  int checks = 0;
  int errors = 0;
  int rd_cycles = 0;
  int wr_cycles = 0;
  logic [XLEN-1:0] last_rdata = '0;
  logic            last_misal = 1'b0;

  function automatic logic [XLEN-1:0] mem_word(input logic [XLEN-1:0] a);
    if (mem.exists(a >> 2)) return mem[a >> 2];
    return 32'hA500_0000 | {a[XLEN-1:2], 2'b00};
  endfunction

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard: compare every cycle ----------------
  always @(negedge clk) begin
    logic [XLEN-1:0] e;
    check("stall", XLEN'(stall), XLEN'(exp_stall));
    check("mem_rd", XLEN'(bus.mem_rd), XLEN'(exp_rd));
    check("mem_wr", XLEN'(bus.mem_wr), XLEN'(exp_wr));
    check("done", XLEN'(done), XLEN'(exp_done));
    check("misaligned", XLEN'(misal), XLEN'(exp_misal));
    if (exp_rd || exp_wr) check("mem_addr", bus.mem_addr, exp_addr);
    if (exp_wr) check("mem_wdata", bus.mem_wdata, exp_wdata);
    if (exp_done) begin
      if (exp_q.size() == 0) begin
        check("exp_q_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("rdata", rdata, e);
        last_rdata = rdata;
        last_misal = misal;
      end
    end
    if (bus.mem_rd) rd_cycles++;
    if (bus.mem_wr) wr_cycles++;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_exp();
    exp_stall = 0; exp_rd = 0; exp_wr = 0; exp_done = 0; exp_misal = 0;
  endtask

  task automatic op(input bit is_sc, input logic [XLEN-1:0] a, input logic [XLEN-1:0] wd,
                    input int waits, input bit flush_mid, input bit snoop_last);
    bit mis, hit, killed;
    mis = (a[1:0] != 2'b00);
    hit = m_valid && (m_word == (a >> 2));
    cyc();
    atomic = 1; sc = is_sc; addr = a; wdata = wd;
    idle_exp(); exp_stall = 1;
    cyc();
    atomic = 0; addr = $urandom; wdata = $urandom;
    if (mis || (is_sc && !hit)) begin
      if (is_sc && !mis) m_valid = 0;
      idle_exp(); exp_done = 1; exp_misal = mis;
      exp_q.push_back(mis ? '0 : XLEN'(SC_FAIL));
    end else begin
      if (is_sc) m_valid = 0;
      killed = 0;
      for (int i = 0; i <= waits; i++) begin
        if (i > 0) cyc();
        idle_exp(); exp_stall = 1; exp_rd = !is_sc; exp_wr = is_sc;
        exp_addr = a; exp_wdata = wd;
        flush = flush_mid && (i == 0);
        if (flush) begin killed = 1; m_valid = 0; end
        bus.mem_ready = (i == waits);
        bus.mem_rdata = (i == waits) ? mem_word(a) : XLEN'($urandom);
        snoop_wr = snoop_last && (i == waits);
        snoop_addr = a;
      end
      cyc();
      flush = 0; snoop_wr = 0; bus.mem_ready = 0;
      idle_exp();
      if (!killed) begin
        exp_done = 1;
        exp_q.push_back(is_sc ? XLEN'(SC_SUCCESS) : mem_word(a));
        if (is_sc) mem[a >> 2] = wd;
        else if (!snoop_last) begin m_valid = 1; m_word = a >> 2; end
      end
    end
    cyc();
    idle_exp();
  endtask

  task automatic snoop_store(input logic [XLEN-1:0] a);
    cyc();
    snoop_wr = 1; snoop_addr = a; idle_exp();
    if (m_valid && (m_word == (a >> 2))) m_valid = 0;
    cyc();
    snoop_wr = 0;
  endtask

  task automatic blocked_by_flush(input logic [XLEN-1:0] a);
    cyc();
    atomic = 1; sc = 0; addr = a; flush = 1; idle_exp();
    m_valid = 0;
    cyc();
    atomic = 0; flush = 0; idle_exp();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int rd0, wr0;
    cyc(); cyc();
    rst = 0;

    rd0 = rd_cycles;
    op(0, 32'h100, 32'h0, 0, 0, 0);
    check("lr100_rdata_lit", last_rdata, 32'hA500_0100);
    check("lr100_rd_cycles", rd_cycles - rd0, 1);

    wr0 = wr_cycles;
    op(1, 32'h100, 32'h0000_DEAD, 3, 0, 0);
    check("sc100_status_lit", last_rdata, 0);
    check("sc100_wr_cycles", wr_cycles - wr0, 4);
    op(1, 32'h100, 32'h1111_1111, 0, 0, 0);
    check("sc_again_fails_lit", last_rdata, 1);

    op(0, 32'h100, 32'h0, 1, 0, 0);
    check("lr_after_sc_lit", last_rdata, 32'h0000_DEAD);
    snoop_store(32'h102);
    wr0 = wr_cycles;
    op(1, 32'h100, 32'h2222_2222, 0, 0, 0);
    check("sc_after_snoop_lit", last_rdata, 1);
    check("sc_after_snoop_no_wr", wr_cycles - wr0, 0);

    rd0 = rd_cycles; wr0 = wr_cycles;
    op(1, 32'h203, 32'h3333_3333, 0, 0, 0);
    check("misal_flag_lit", XLEN'(last_misal), 1);
    check("misal_rdata_lit", last_rdata, 0);
    check("misal_no_access", (rd_cycles - rd0) + (wr_cycles - wr0), 0);

    op(0, 32'h200, 32'h0, 0, 0, 0);
    op(0, 32'h101, 32'h0, 0, 0, 0);
    op(1, 32'h200, 32'h4444_4444, 1, 0, 0);
    check("misal_keeps_res_lit", last_rdata, 0);

    op(0, 32'h180, 32'h0, 1, 1, 0);
    op(1, 32'h180, 32'h5555_5555, 0, 0, 0);
    check("sc_after_flushed_lr_lit", last_rdata, 1);

    op(0, 32'h240, 32'h0, 0, 0, 1);
    op(1, 32'h240, 32'h6666_6666, 0, 0, 0);
    check("sc_after_racing_snoop_lit", last_rdata, 1);

    op(0, 32'h400, 32'h0, 0, 0, 0);
    blocked_by_flush(32'h500);
    op(1, 32'h400, 32'h7777_7777, 0, 0, 0);
    check("sc_after_idle_flush_lit", last_rdata, 1);

    // Reset in the middle of a successful SC write.
    op(0, 32'h300, 32'h0, 0, 0, 0);
    cyc();
    atomic = 1; sc = 1; addr = 32'h300; wdata = 32'h8888_8888;
    idle_exp(); exp_stall = 1;
    cyc();
    atomic = 0; m_valid = 0;
    idle_exp(); exp_stall = 1; exp_wr = 1; exp_addr = 32'h300; exp_wdata = 32'h8888_8888;
    cyc();
    #2;
    rst = 1;
    #1;
    check("async_wr_drop", XLEN'(bus.mem_wr), 0);
    check("async_stall_drop", XLEN'(stall), 0);
    idle_exp();
    cyc(); cyc();
    rst = 0;
    cyc();
    op(1, 32'h300, 32'h9999_9999, 0, 0, 0);
    check("sc_after_reset_lit", last_rdata, 1);

    for (int k = 0; k < 6; k++) begin
      op(0, 32'h1000 + 32'(k * 8), 32'h0, $urandom_range(0, 3), 0, 0);
      op(1, 32'h1000 + 32'(k * 8), $urandom, $urandom_range(0, 3), 0, 0);
    end

    cyc(); cyc();
    check("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
